pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage LC-3b pipeline. It is the initiator side of the latch load/squash interface: it drives load and squash into the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and load into the PC.
- Resolves three hazard classes: data-memory stalls, load-use hazards and taken-branch redirects.
- Holds a pending redirect across an in-flight instruction fetch so the wrong-path fetch completes before the PC is redirected.

Parameters:
- ADDR_W, 16, width of PC / branch target
- REG_W, 3, register specifier width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- imem_read  in  1  IF stage has an instruction fetch outstanding
- imem_resp  in  1  instruction memory response this cycle
- dmem_req  in  1  MEM stage instruction is accessing data memory
- dmem_resp  in  1  data memory response this cycle
- id_sr1, id_sr2  in  REG_W  source registers of the instruction in ID
- id_uses_sr1, id_uses_sr2  in  1  the ID instruction actually reads that source
- ex_dest  in  REG_W  destination register of the instruction in EX
- ex_is_load  in  1  the EX instruction is LDR/LDB/LDI
- br_taken  in  1  MEM stage resolved a taken branch, JMP, JSR or TRAP
- br_target  in  ADDR_W  redirect address from MEM
- load_pc  out  1  PC register load
- pc_redirect  out  1  PC mux selects redirect_target
- redirect_target  out  ADDR_W  target to load into the PC
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  per-latch load
- squash_if_id, squash_id_ex, squash_ex_mem  out  1  per-latch bubble insert

Behaviour:
- States: RUN and REDIR_WAIT. Reset gives state=RUN, saved target=0.
- While reset=1, every load and squash output is 0, pc_redirect is 0 and redirect_target is 0.
- A squash output is meaningful only when the matching load is 1.
- Outputs are combinational from the state and inputs. The only registers are the state, the saved target, and the counters when PERF_CNT_EN is defined.
- dstall = dmem_req & ~dmem_resp.
- lu_hazard = ex_is_load & ((id_uses_sr1 & id_sr1==ex_dest) | (id_uses_sr2 & id_sr2==ex_dest)).
- istall = imem_read & ~imem_resp.
- Priority, highest first: dstall, br_taken, lu_hazard, istall, normal advance.
- RUN, dstall: all loads 0, all squashes 0. The whole pipe freezes and br_taken is ignored until dstall clears.
- RUN, br_taken with ~istall:
  - All loads 1.
  - squash_if_id, squash_id_ex and squash_ex_mem all 1.
  - pc_redirect=1, redirect_target=br_target, same cycle. Stay in RUN.
- RUN, br_taken with istall:
  - squash_id_ex=1 and squash_ex_mem=1; load_id_ex, load_ex_mem and load_mem_wb all 1.
  - load_pc=0, load_if_id=0.
  - Save br_target and go to REDIR_WAIT.
- RUN, lu_hazard: load_pc=0, load_if_id=0; load_id_ex=1 with squash_id_ex=1; load_ex_mem=1, load_mem_wb=1. This gives exactly one bubble, because next cycle the load is in MEM.
- RUN, istall only: load_pc=0; load_if_id=1 with squash_if_id=1; downstream latches load normally.
- RUN, normal advance: all loads 1, squashes 0.
- REDIR_WAIT, ~imem_resp:
  - load_pc=0, load_if_id=0.
  - Downstream latches load bubbles: squash_id_ex=1 and squash_ex_mem=1, all loads 1.
  - If dstall is also asserted, everything freezes instead.
- REDIR_WAIT, imem_resp:
  - load_pc=1, pc_redirect=1, redirect_target=saved target.
  - load_if_id=1 with squash_if_id=1, so the wrong-path fetch is discarded.
  - Return to RUN.
- A new br_taken in REDIR_WAIT is impossible, because only bubbles occupy MEM. The bench asserts this.
- Reset mid-REDIR_WAIT: the state returns to RUN next edge and the pending redirect is dropped.

Optional Feature:
PERF_CNT_EN, when defined, adds:
- Outputs stall_cycles[31:0] and squash_events[31:0].
- stall_cycles increments every cycle that load_pc=0 outside reset.
- squash_events increments once per br_taken acceptance.
- Both counters clear on reset and wrap at 2^32.

When PERF_CNT_EN is undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package lc3b_types gains:
  - hazard_state_t enum {HZ_RUN, HZ_REDIR_WAIT}
  - lc3b_reg (3-bit)
- redirect_target reuses lc3b_word.
- One sub-module, load_use_detect: combinational comparator producing lu_hazard. It is kept separate so forwarding logic can reuse it.

Test Plan:
- Load-use: EX=LDR R2, ID=ADD R1,R2,R3 -> one cycle of load_pc=0, load_if_id=0, squash_id_ex=1; next cycle all loads 1.
- Dmem miss: dmem_req=1, dmem_resp low for 4 cycles, br_taken=1 concurrently -> all loads 0 for 4 cycles; the redirect takes effect the cycle dmem_resp=1.
- Branch without fetch pending: br_taken=1, br_target=16'h3040, imem idle -> same cycle: three squashes =1, pc_redirect=1, redirect_target=16'h3040.
- Branch with fetch pending: br_taken=1, br_target=16'h0120, imem_resp arrives 3 cycles later -> load_pc=0 for 3 cycles; then load_pc=1, pc_redirect=1, redirect_target=16'h0120, squash_if_id=1.
- Reset in REDIR_WAIT: assert reset one cycle after entering REDIR_WAIT -> outputs all 0 during reset; after release the state is RUN, and the next imem_resp gives no redirect.
- With PERF_CNT_EN defined: run the three previous stall scenarios -> stall_cycles=8, squash_events=2.

Source files
------------

// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types: machine word, register specifier and the
// hazard controller state encoding.
package lc3b_types;

    localparam int LC3B_WORD_W = 16;
    localparam int LC3B_REG_W  = 3;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [LC3B_REG_W-1:0]  lc3b_reg;

    typedef enum logic {
        HZ_RUN        = 1'b0,
        HZ_REDIR_WAIT = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load still in EX. Kept standalone so forwarding logic can share it.
module load_use_detect #(
    parameter int REG_W = 3
) (
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_dest,
    input  logic [REG_W-1:0] id_sr1,
    input  logic [REG_W-1:0] id_sr2,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    output logic             lu_hazard
);

    // A match on an unused source field is not a dependency.
    always_comb begin
        lu_hazard = ex_is_load &
                    ((id_uses_sr1 & (id_sr1 == ex_dest)) |
                     (id_uses_sr2 & (id_sr2 == ex_dest)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipeline. Drives load/squash
// into every pipeline latch and load/redirect into the PC.
// Optional feature macro: PERF_CNT_EN adds stall_cycles / squash_events.
module pipeline_hazard_ctrl
    import lc3b_types::*;
#(
    parameter int ADDR_W = LC3B_WORD_W,
    parameter int REG_W  = LC3B_REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_read,
    input  logic              imem_resp,
    input  logic              dmem_req,
    input  logic              dmem_resp,
    input  logic [REG_W-1:0]  id_sr1,
    input  logic [REG_W-1:0]  id_sr2,
    input  logic              id_uses_sr1,
    input  logic              id_uses_sr2,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic              ex_is_load,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              load_pc,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_target,
    output logic              load_if_id,
    output logic              load_id_ex,
    output logic              load_ex_mem,
    output logic              load_mem_wb,
    output logic              squash_if_id,
    output logic              squash_id_ex,
    output logic              squash_ex_mem
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       squash_events
`endif
);

    hazard_state_t     state, next_state;
    logic [ADDR_W-1:0] saved_target, next_saved_target;
    logic              dstall, istall, lu_hazard;
    logic              br_accept;

    assign dstall = dmem_req & ~dmem_resp;
    assign istall = imem_read & ~imem_resp;

    load_use_detect #(.REG_W(REG_W)) u_lu (
        .ex_is_load  (ex_is_load),
        .ex_dest     (ex_dest),
        .id_sr1      (id_sr1),
        .id_sr2      (id_sr2),
        .id_uses_sr1 (id_uses_sr1),
        .id_uses_sr2 (id_uses_sr2),
        .lu_hazard   (lu_hazard)
    );

    // State and pending redirect target; reset drops any pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HZ_RUN;
            saved_target <= '0;
        end else begin
            state        <= next_state;
            saved_target <= next_saved_target;
        end
    end

    // Hazard priority resolution: dstall > br_taken > load-use > istall.
    always_comb begin
        next_state        = state;
        next_saved_target = saved_target;
        br_accept         = 1'b0;
        load_pc           = 1'b0;
        pc_redirect       = 1'b0;
        redirect_target   = '0;
        load_if_id        = 1'b0;
        load_id_ex        = 1'b0;
        load_ex_mem       = 1'b0;
        load_mem_wb       = 1'b0;
        squash_if_id      = 1'b0;
        squash_id_ex      = 1'b0;
        squash_ex_mem     = 1'b0;

        if (!reset) begin
            unique case (state)
                HZ_RUN: begin
                    if (dstall) begin
                        // Whole pipe frozen; a resolved branch waits in MEM.
                    end else if (br_taken) begin
                        br_accept     = 1'b1;
                        load_id_ex    = 1'b1;
                        load_ex_mem   = 1'b1;
                        load_mem_wb   = 1'b1;
                        squash_id_ex  = 1'b1;
                        squash_ex_mem = 1'b1;
                        if (!istall) begin
                            load_pc         = 1'b1;
                            pc_redirect     = 1'b1;
                            redirect_target = br_target;
                            load_if_id      = 1'b1;
                            squash_if_id    = 1'b1;
                        end else begin
                            // Let the wrong-path fetch land before redirecting.
                            next_saved_target = br_target;
                            next_state        = HZ_REDIR_WAIT;
                        end
                    end else if (lu_hazard) begin
                        // One bubble suffices: next cycle the load sits in MEM.
                        load_id_ex   = 1'b1;
                        squash_id_ex = 1'b1;
                        load_ex_mem  = 1'b1;
                        load_mem_wb  = 1'b1;
                    end else if (istall) begin
                        load_if_id   = 1'b1;
                        squash_if_id = 1'b1;
                        load_id_ex   = 1'b1;
                        load_ex_mem  = 1'b1;
                        load_mem_wb  = 1'b1;
                    end else begin
                        load_pc     = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end
                end
                HZ_REDIR_WAIT: begin
                    if (imem_resp) begin
                        // Discard the wrong-path fetch and take the redirect.
                        load_pc         = 1'b1;
                        pc_redirect     = 1'b1;
                        redirect_target = saved_target;
                        load_if_id      = 1'b1;
                        squash_if_id    = 1'b1;
                        load_id_ex      = 1'b1;
                        squash_id_ex    = 1'b1;
                        load_ex_mem     = 1'b1;
                        squash_ex_mem   = 1'b1;
                        load_mem_wb     = 1'b1;
                        next_state      = HZ_RUN;
                    end else if (!dstall) begin
                        // IF/ID holds a stale wrong-path op; keep it out of ID/EX.
                        load_id_ex    = 1'b1;
                        squash_id_ex  = 1'b1;
                        load_ex_mem   = 1'b1;
                        squash_ex_mem = 1'b1;
                        load_mem_wb   = 1'b1;
                    end
                end
                default: next_state = HZ_RUN;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Performance counters: PC-stall cycles and accepted branch redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            squash_events <= '0;
        end else begin
            if (!load_pc)  stall_cycles  <= stall_cycles + 32'd1;
            if (br_accept) squash_events <= squash_events + 32'd1;
        end
    end
`endif

endmodule
